// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier controller.
package mult_pkg;

  localparam int MULT_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ADD,
    SHIFT,
    DONE
  } mult_state_t;

endpackage

// File: rtl/mult_seq_ctrl.sv
// Sequencer for a radix-2 shift-add multiplier: handshakes an operation in, steps the
// external A/B/M datapath through WIDTH add/shift iterations, and handshakes the product out.
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter  int WIDTH = MULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Req_Valid,
  output logic             Req_Ready,
  input  logic             Req_Signed,
  input  logic             Abort,
  output logic             Resp_Valid,
  input  logic             Resp_Ready,
  input  logic             B_Lsb,
  input  logic             Sum_X,
  output logic             Clr_A,
  output logic             Ld_B,
  output logic             Ld_M,
  output logic             Ld_A,
  output logic             Sub,
  output logic             Shift_En,
  output logic             A_Shift_In,
  output logic             Busy,
  output logic [CNT_W-1:0] Count
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  mult_state_t      state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             x_q, x_d;
  logic             signed_q, signed_d;
  logic             req_ready_q, resp_valid_q, busy_q;
  logic             clr_a_q, ld_b_q, ld_m_q, shift_en_q;
  logic             last_iter;

  assign last_iter = (count_q == LAST_CNT);

  // X carries the bit above A: the adder carry for unsigned, the running sign of A for signed.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    x_d      = x_q;
    signed_d = signed_q;
    case (state_q)
      IDLE: begin
        if (Req_Valid) begin
          state_d  = LOAD;
          signed_d = Req_Signed;
        end
      end
      LOAD: begin
        state_d = ADD;
        count_d = '0;
        x_d     = 1'b0;
      end
      ADD: begin
        state_d = SHIFT;
        x_d     = B_Lsb ? Sum_X : (signed_q & x_q);
      end
      SHIFT: begin
        x_d = signed_q & x_q;
        if (last_iter) begin
          state_d = DONE;
        end else begin
          state_d = ADD;
          count_d = count_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (Resp_Ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (Abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end
    if ((state_d == IDLE) && (state_q != IDLE)) begin
      count_d = '0;
      x_d     = 1'b0;
    end
  end

  // Moore strobes are registered from the next state so they line up with state_q.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      count_q      <= '0;
      x_q          <= 1'b0;
      signed_q     <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      clr_a_q      <= 1'b0;
      ld_b_q       <= 1'b0;
      ld_m_q       <= 1'b0;
      shift_en_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      x_q          <= x_d;
      signed_q     <= signed_d;
      req_ready_q  <= (state_d == IDLE);
      resp_valid_q <= (state_d == DONE);
      busy_q       <= (state_d != IDLE);
      clr_a_q      <= (state_d == LOAD);
      ld_b_q       <= (state_d == LOAD);
      ld_m_q       <= (state_d == LOAD);
      shift_en_q   <= (state_d == SHIFT);
    end
  end

  assign Req_Ready  = req_ready_q;
  assign Resp_Valid = resp_valid_q;
  assign Busy       = busy_q;
  assign Clr_A      = clr_a_q;
  assign Ld_B       = ld_b_q;
  assign Ld_M       = ld_m_q;
  assign Shift_En   = shift_en_q;
  assign A_Shift_In = x_q;
  assign Count      = count_q;

  // Signed operands weight the multiplier MSB negatively, so the last add becomes a subtract.
  assign Ld_A = (state_q == ADD) & B_Lsb;
  assign Sub  = Ld_A & signed_q & last_iter;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// End-to-end bench: drives mult_seq_ctrl together with a behavioural A/B/M/adder datapath
// and compares finished products, latency and handshake behaviour against hand-computed values.
module tb_mult_seq_ctrl;
  import mult_pkg::*;

  localparam int W  = MULT_WIDTH;
  localparam int CW = $clog2(W);
  localparam int LATENCY = 2 * W + 2;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic          Req_Valid, Req_Ready, Req_Signed, Abort;
  logic          Resp_Valid, Resp_Ready;
  logic          B_Lsb, Sum_X;
  logic          Clr_A, Ld_B, Ld_M, Ld_A, Sub, Shift_En, A_Shift_In, Busy;
  logic [CW-1:0] Count;

  logic [W-1:0]  regA, regB, regM, opM, opB;
  logic          curSigned;
  logic [W:0]    extA, extM, sum;

  int checks = 0;
  int errors = 0;
  int subPulses = 0;
  logic [CW-1:0] subCountAt = '0;

  typedef struct {
    string        name;
    logic [W-1:0] m;
    logic [W-1:0] b;
    logic         sgn;
    logic [63:0]  prod;
    int           subs;
  } vec_t;

  vec_t vecs[10];

  mult_seq_ctrl #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .Req_Valid(Req_Valid), .Req_Ready(Req_Ready), .Req_Signed(Req_Signed), .Abort(Abort),
    .Resp_Valid(Resp_Valid), .Resp_Ready(Resp_Ready),
    .B_Lsb(B_Lsb), .Sum_X(Sum_X),
    .Clr_A(Clr_A), .Ld_B(Ld_B), .Ld_M(Ld_M), .Ld_A(Ld_A), .Sub(Sub),
    .Shift_En(Shift_En), .A_Shift_In(A_Shift_In), .Busy(Busy), .Count(Count)
  );

  always #5 Clk = ~Clk;

  // Behavioural datapath: two shift registers, multiplicand register, WIDTH+1 bit add/sub.
  always_comb begin
    extA = {curSigned & regA[W-1], regA};
    extM = {curSigned & regM[W-1], regM};
    sum  = Sub ? (extA - extM) : (extA + extM);
  end

  assign Sum_X = sum[W];
  assign B_Lsb = regB[0];

  always @(posedge Clk) begin
    if (Clr_A)         regA <= '0;
    else if (Ld_A)     regA <= sum[W-1:0];
    else if (Shift_En) regA <= {A_Shift_In, regA[W-1:1]};
    if (Ld_B)          regB <= opB;
    else if (Shift_En) regB <= {regA[0], regB[W-1:1]};
    if (Ld_M)          regM <= opM;
  end

  always @(negedge Clk) begin
    if (Sub) begin
      subPulses  <= subPulses + 1;
      subCountAt <= Count;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic startOp(input logic [W-1:0] m, input logic [W-1:0] b, input logic sgn,
                         input logic abortToo);
    @(negedge Clk);
    opM        = m;
    opB        = b;
    curSigned  = sgn;
    Req_Signed = sgn;
    Req_Valid  = 1'b1;
    Abort      = abortToo;
    for (int i = 0; i < 200 && !Req_Ready; i++) @(negedge Clk);
    @(posedge Clk);
    #1;
    Req_Valid = 1'b0;
    Abort     = 1'b0;
  endtask

  // Returns the edge (counted from the accepting edge) at which Resp_Valid is first seen high.
  task automatic applyStimulus(input logic [W-1:0] m, input logic [W-1:0] b, input logic sgn,
                               input logic abortToo, output int lat);
    lat = -1;
    startOp(m, b, sgn, abortToo);
    for (int i = 1; i <= 200; i++) begin
      @(negedge Clk);
      if (Resp_Valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic releaseResp(input string name);
    Resp_Ready = 1'b1;
    @(negedge Clk);
    Resp_Ready = 1'b0;
    checkOutput({name, " busy after resp"}, 64'(Busy), 64'd0);
    checkOutput({name, " ready after resp"}, 64'(Req_Ready), 64'd1);
    checkOutput({name, " valid after resp"}, 64'(Resp_Valid), 64'd0);
  endtask

  initial begin
    int lat;
    int subBefore;
    int found;
    logic stayed;

    vecs[0] = '{"u 3x5",           32'h00000003, 32'h00000005, 1'b0, 64'h00000000_0000000F, 0};
    vecs[1] = '{"u ffff x ffff",   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001, 0};
    vecs[2] = '{"s -3x5",          32'hFFFFFFFD, 32'h00000005, 1'b1, 64'hFFFFFFFF_FFFFFFF1, 0};
    vecs[3] = '{"s 5x-3",          32'h00000005, 32'hFFFFFFFD, 1'b1, 64'hFFFFFFFF_FFFFFFF1, 1};
    vecs[4] = '{"s min x min",     32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000, 1};
    vecs[5] = '{"s -1x-1",         32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h00000000_00000001, 1};
    vecs[6] = '{"u shift16",       32'h12345678, 32'h00000010, 1'b0, 64'h00000001_23456780, 0};
    vecs[7] = '{"s max x max",     32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 64'h3FFFFFFF_00000001, 0};
    vecs[8] = '{"u 0 x ffff",      32'h00000000, 32'hFFFFFFFF, 1'b0, 64'h00000000_00000000, 0};
    vecs[9] = '{"s min x 1",       32'h80000000, 32'h00000001, 1'b1, 64'hFFFFFFFF_80000000, 0};

    Reset_n    = 1'b0;
    Req_Valid  = 1'b0;
    Req_Signed = 1'b0;
    Abort      = 1'b0;
    Resp_Ready = 1'b0;
    opM        = '0;
    opB        = '0;
    curSigned  = 1'b0;
    repeat (3) @(negedge Clk);
    checkOutput("reset req_ready", 64'(Req_Ready), 64'd1);
    checkOutput("reset resp_valid", 64'(Resp_Valid), 64'd0);
    checkOutput("reset busy", 64'(Busy), 64'd0);
    checkOutput("reset count", 64'(Count), 64'd0);
    checkOutput("reset strobes", 64'({Clr_A, Ld_B, Ld_M, Ld_A, Sub, Shift_En, A_Shift_In}), 64'd0);
    Reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      subBefore = subPulses;
      applyStimulus(vecs[i].m, vecs[i].b, vecs[i].sgn, 1'b0, lat);
      checkOutput({vecs[i].name, " latency"}, 64'(lat), 64'(LATENCY));
      checkOutput({vecs[i].name, " product"}, {regA, regB}, vecs[i].prod);
      checkOutput({vecs[i].name, " sub pulses"}, 64'(subPulses - subBefore), 64'(vecs[i].subs));
      if (subPulses != subBefore)
        checkOutput({vecs[i].name, " sub count"}, 64'(subCountAt), 64'(W - 1));
      releaseResp(vecs[i].name);
    end

    // Consumer stalls in DONE while a new request is waiting.
    applyStimulus(32'h00001234, 32'h00000100, 1'b0, 1'b0, lat);
    checkOutput("stall latency", 64'(lat), 64'(LATENCY));
    opM       = 32'h0000000B;
    opB       = 32'h0000000D;
    Req_Valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      checkOutput("stall resp_valid", 64'(Resp_Valid), 64'd1);
      checkOutput("stall product", {regA, regB}, 64'h00000000_00123400);
      checkOutput("stall req_ready", 64'(Req_Ready), 64'd0);
    end
    Req_Valid = 1'b0;
    releaseResp("stall");
    applyStimulus(32'h00000009, 32'h00000009, 1'b0, 1'b0, lat);
    checkOutput("after stall latency", 64'(lat), 64'(LATENCY));
    checkOutput("after stall product", {regA, regB}, 64'd81);
    releaseResp("after stall");

    // Abort in SHIFT at Count 12 with a negative partial product, so X is set.
    startOp(32'hFFFFFFF9, 32'h00007FFF, 1'b1, 1'b0);
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge Clk);
      if (Shift_En && Count == CW'(12)) begin
        found = 1;
        break;
      end
    end
    checkOutput("abort reached count12", 64'(found), 64'd1);
    checkOutput("abort x before", 64'(A_Shift_In), 64'd1);
    Abort = 1'b1;
    @(negedge Clk);
    Abort = 1'b0;
    checkOutput("abort busy", 64'(Busy), 64'd0);
    checkOutput("abort req_ready", 64'(Req_Ready), 64'd1);
    checkOutput("abort count", 64'(Count), 64'd0);
    checkOutput("abort x cleared", 64'(A_Shift_In), 64'd0);
    stayed = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      if (Resp_Valid || Busy) stayed = 1'b0;
    end
    checkOutput("abort stays idle", 64'(stayed), 64'd1);
    // Abort in IDLE is ignored and the same-cycle request still goes through.
    applyStimulus(32'h00000007, 32'h00000006, 1'b0, 1'b1, lat);
    checkOutput("7x6 latency", 64'(lat), 64'(LATENCY));
    checkOutput("7x6 product", {regA, regB}, 64'd42);
    releaseResp("7x6");

    // Asynchronous reset mid-ADD, between clock edges.
    startOp(32'h00001111, 32'h00000003, 1'b0, 1'b0);
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge Clk);
      if (Busy && !Shift_En && !Clr_A && !Resp_Valid && Count == CW'(3)) begin
        found = 1;
        break;
      end
    end
    checkOutput("reset reached add", 64'(found), 64'd1);
    #2;
    Reset_n = 1'b0;
    #1;
    checkOutput("async reset busy", 64'(Busy), 64'd0);
    checkOutput("async reset req_ready", 64'(Req_Ready), 64'd1);
    checkOutput("async reset count", 64'(Count), 64'd0);
    checkOutput("async reset strobes", 64'({Clr_A, Ld_B, Ld_M, Ld_A, Sub, Shift_En, Resp_Valid}), 64'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    applyStimulus(32'h00000002, 32'h00000002, 1'b0, 1'b0, lat);
    checkOutput("2x2 latency", 64'(lat), 64'(LATENCY));
    checkOutput("2x2 product", {regA, regB}, 64'd4);
    releaseResp("2x2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
